// File: rtl/codec_arb_pkg.sv
// ============================================================================
// Module : codec_arb_pkg
// Brief  : Shared types and constants for the CODEC I2C arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package codec_arb_pkg;

  localparam int NUM_REQ  = 2;
  localparam int REQ_HOST = 0;
  localparam int REQ_SEQ  = 1;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/codec_arb_rr_pick.sv
// ============================================================================
// Module : codec_arb_rr_pick
// Brief  : Two-way round-robin pick; on contention the requester not granted
//          last wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module codec_arb_rr_pick
  import codec_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_last_grant,
  output logic               o_grant,
  output logic               o_grant_valid
);

  always_comb begin
    o_grant       = 1'b0;
    o_grant_valid = |i_req_valid;
    case (i_req_valid)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/codec_i2c_arbiter.sv
// ============================================================================
// Module : codec_i2c_arbiter
// Brief  : Shares one CODEC I2C controller between host and sequencer.
//          Define CODEC_ARB_TIMEOUT_EN to bound the controller waits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module codec_i2c_arbiter
  import codec_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
)(
  input  logic                      board_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_is_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  input  logic                      init_done,
  output logic                      codec_rd_en,
  output logic                      codec_wr_en,
  output logic [ADDR_W-1:0]         codec_reg_addr,
  output logic [DATA_W-1:0]         codec_data_in,
  input  logic                      controller_busy,
  input  logic [DATA_W-1:0]         codec_data_out,
  input  logic                      codec_data_out_valid
);

  arb_state_e          r_state;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_is_wr;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_grant;
  logic                w_grant_valid;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_rdata_next;

  codec_arb_rr_pick u_pick (
    .i_req_valid   (req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  assign w_sel_wr     = w_grant ? req_is_wr[1]    : req_is_wr[0];
  assign w_sel_addr   = w_grant ? req_addr[15:8]  : req_addr[7:0];
  assign w_sel_wdata  = w_grant ? req_wdata[15:8] : req_wdata[7:0];
  // Read data arriving in the same cycle busy drops must still reach the response.
  assign w_rdata_next = codec_data_out_valid ? codec_data_out : r_rdata;

`ifdef CODEC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_error;
  logic             w_timeout;

  assign w_timeout = (r_cnt == CNT_MAX);
  assign rsp_error = r_rsp_error;
`else
  assign rsp_error = 1'b0;
`endif

  always_ff @(posedge board_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_owner        <= 1'b0;
      r_is_wr        <= 1'b0;
      r_rdata        <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      codec_rd_en    <= 1'b0;
      codec_wr_en    <= 1'b0;
      codec_reg_addr <= '0;
      codec_data_in  <= '0;
`ifdef CODEC_ARB_TIMEOUT_EN
      r_cnt          <= '0;
      r_rsp_error    <= 1'b0;
`endif
    end else begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      codec_rd_en <= 1'b0;
      codec_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init_done && w_grant_valid) begin
            req_ready[w_grant] <= 1'b1;
            r_owner            <= w_grant;
            r_last_grant       <= w_grant;
            r_is_wr            <= w_sel_wr;
            r_rdata            <= '0;
            codec_reg_addr     <= w_sel_addr;
            codec_data_in      <= w_sel_wdata;
            codec_wr_en        <= w_sel_wr;
            codec_rd_en        <= ~w_sel_wr;
            r_state            <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CODEC_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
`ifdef CODEC_ARB_TIMEOUT_EN
          if (w_timeout) begin
            rsp_valid[r_owner] <= 1'b1;
            rsp_rdata          <= '0;
            r_rsp_error        <= 1'b1;
            r_state            <= RESP;
          end else if (controller_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
`else
          if (controller_busy) r_state <= WAIT_DONE;
`endif
        end
        WAIT_DONE: begin
          if (codec_data_out_valid) r_rdata <= codec_data_out;
`ifdef CODEC_ARB_TIMEOUT_EN
          if (w_timeout) begin
            rsp_valid[r_owner] <= 1'b1;
            rsp_rdata          <= '0;
            r_rsp_error        <= 1'b1;
            r_state            <= RESP;
          end else if (!controller_busy) begin
            rsp_valid[r_owner] <= 1'b1;
            rsp_rdata          <= r_is_wr ? '0 : w_rdata_next;
            r_rsp_error        <= 1'b0;
            r_state            <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`else
          if (!controller_busy) begin
            rsp_valid[r_owner] <= 1'b1;
            rsp_rdata          <= r_is_wr ? '0 : w_rdata_next;
            r_state            <= RESP;
          end
`endif
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_codec_i2c_arbiter.sv
// ============================================================================
// Module : tb_codec_i2c_arbiter
// Brief  : Directed self-checking bench for codec_i2c_arbiter; the timeout
//          scenario runs only when CODEC_ARB_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_codec_i2c_arbiter;

`ifdef CODEC_ARB_TIMEOUT_EN
  localparam int unsigned c_timeout = 64;
`else
  localparam int unsigned c_timeout = 1000000;
`endif

  logic        board_clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_is_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        init_done;
  logic        codec_rd_en;
  logic        codec_wr_en;
  logic [7:0]  codec_reg_addr;
  logic [7:0]  codec_data_in;
  logic        controller_busy;
  logic [7:0]  codec_data_out;
  logic        codec_data_out_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #10 board_clk = ~board_clk;

  codec_i2c_arbiter #(.TIMEOUT_CYCLES(c_timeout)) dut (
    .board_clk            (board_clk),
    .reset_n              (reset_n),
    .req_valid            (req_valid),
    .req_is_wr            (req_is_wr),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_rdata            (rsp_rdata),
    .rsp_error            (rsp_error),
    .init_done            (init_done),
    .codec_rd_en          (codec_rd_en),
    .codec_wr_en          (codec_wr_en),
    .codec_reg_addr       (codec_reg_addr),
    .codec_data_in        (codec_data_in),
    .controller_busy      (controller_busy),
    .codec_data_out       (codec_data_out),
    .codec_data_out_valid (codec_data_out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, req_ready, rsp_valid, rsp_rdata, rsp_error,
            codec_rd_en, codec_wr_en, codec_reg_addr} | {24'd0, codec_data_in};
  endfunction

  // Plays the controller for one granted transaction and checks the response.
  task automatic serve(input string tag, input int owner, input bit is_wr,
                       input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] ret, input int delay, input int len,
                       input bit drop);
    logic [1:0] onehot;
    int n;
    onehot = (owner == 1) ? 2'b10 : 2'b01;
    n = 0;
    while (req_ready == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("%s_ready", tag), {30'd0, req_ready}, {30'd0, onehot});
    chk($sformatf("%s_strobe", tag), {30'd0, codec_wr_en, codec_rd_en},
        is_wr ? 32'd2 : 32'd1);
    chk($sformatf("%s_addr", tag), {24'd0, codec_reg_addr}, {24'd0, addr});
    if (is_wr) chk($sformatf("%s_wdata", tag), {24'd0, codec_data_in}, {24'd0, wdata});
    if (drop) req_valid[owner] = 1'b0;
    tick();
    chk($sformatf("%s_pulse", tag), {28'd0, req_ready, codec_wr_en, codec_rd_en}, 32'd0);
    repeat (delay - 1) tick();
    controller_busy = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) begin
        codec_data_out_valid = 1'b1;
        codec_data_out       = ret;
      end
      tick();
    end
    chk($sformatf("%s_addr_hold", tag), {24'd0, codec_reg_addr}, {24'd0, addr});
    controller_busy      = 1'b0;
    codec_data_out_valid = 1'b0;
    codec_data_out       = 8'hEE;
    n = 0;
    while (rsp_valid == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("%s_rsp", tag), {30'd0, rsp_valid}, {30'd0, onehot});
    chk($sformatf("%s_rdata", tag), {24'd0, rsp_rdata}, is_wr ? 32'd0 : {24'd0, ret});
    chk($sformatf("%s_err", tag), {31'd0, rsp_error}, 32'd0);
    tick();
    chk($sformatf("%s_rsp_pulse", tag), {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int bad;
    int n;
    reset_n              = 1'b0;
    req_valid            = 2'b00;
    req_is_wr            = 2'b00;
    req_addr             = 16'h0000;
    req_wdata            = 16'h0000;
    init_done            = 1'b0;
    controller_busy      = 1'b0;
    codec_data_out       = 8'h00;
    codec_data_out_valid = 1'b0;
    #5;
    chk("reset_outs", all_outs(), 32'd0);
    tick();
    tick();
    reset_n   = 1'b1;
    init_done = 1'b1;
    tick();

    // Host write 0x10 <= 0x5A, busy 3 cycles after strobe for 20 cycles
    req_is_wr = 2'b01; req_addr = 16'h0010; req_wdata = 16'h005A; req_valid = 2'b01;
    serve("host_wr", 0, 1'b1, 8'h10, 8'h5A, 8'h00, 3, 20, 1'b1);

    // Sequencer read 0x02 returns 0xC3
    req_is_wr = 2'b00; req_addr = 16'h0200; req_valid = 2'b10;
    serve("seq_rd", 1, 1'b0, 8'h02, 8'h00, 8'hC3, 2, 5, 1'b1);
    repeat (3) tick();
    chk("rdata_hold", {24'd0, rsp_rdata}, 32'h0000_00C3);

    // Both valid continuously: host write / seq read alternate
    req_is_wr = 2'b01; req_addr = 16'h0320; req_wdata = 16'h0011; req_valid = 2'b11;
    serve("rr0_host", 0, 1'b1, 8'h20, 8'h11, 8'h00, 1, 2, 1'b0);
    serve("rr1_seq",  1, 1'b0, 8'h03, 8'h00, 8'h7E, 2, 3, 1'b0);
    serve("rr2_host", 0, 1'b1, 8'h20, 8'h11, 8'h00, 1, 1, 1'b0);
    serve("rr3_seq",  1, 1'b0, 8'h03, 8'h00, 8'h81, 1, 4, 1'b0);
    req_valid = 2'b00;

    // Grants gated by init_done; seq drops its request before any grant
    init_done = 1'b0;
    req_is_wr = 2'b00; req_addr = 16'h0544; req_valid = 2'b11;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) req_valid[1] = 1'b0;
      tick();
      if (req_ready != 2'b00 || codec_wr_en || codec_rd_en) bad++;
    end
    chk("init_gate", bad, 0);
    init_done = 1'b1;
    tick();
    chk("init_grant", {30'd0, req_ready}, 32'd1);
    init_done = 1'b0;
    serve("init_low_mid", 0, 1'b0, 8'h44, 8'h00, 8'h5C, 1, 2, 1'b1);
    init_done = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready != 2'b00 || rsp_valid != 2'b00) bad++;
    end
    chk("drop_seq", bad, 0);

    // Reset during WAIT_DONE after a host grant
    req_is_wr = 2'b00; req_addr = 16'h0066; req_valid = 2'b01;
    tick();
    chk("rst_pre_ready", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();
    controller_busy = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", all_outs(), 32'd0);
    controller_busy = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid != 2'b00) bad++;
    end
    chk("rst_no_rsp", bad, 0);
    req_is_wr = 2'b01; req_addr = 16'h0866; req_wdata = 16'h3300; req_valid = 2'b11;
    tick();
    chk("rst_host_first", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    serve("rst_after", 0, 1'b1, 8'h66, 8'h00, 8'h00, 1, 1, 1'b1);

`ifdef CODEC_ARB_TIMEOUT_EN
    // Busy never rises: error response 64 cycles after entering WAIT_BUSY
    req_is_wr = 2'b00; req_addr = 16'h0077; req_valid = 2'b01;
    tick();
    chk("to_ready", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();
    n = 0;
    while (rsp_valid == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", n, 64);
    chk("to_rsp", {30'd0, rsp_valid}, 32'd1);
    chk("to_err", {31'd0, rsp_error}, 32'd1);
    chk("to_rdata", {24'd0, rsp_rdata}, 32'd0);
`else
    n = 0;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
